// File: rtl/config_reg.sv
// rtl/config_reg.sv - addressable configuration register node on a daisy-chained config bus
// Writes/reads its stored value on address match; otherwise forwards the message one cycle later.
module config_reg #(
  parameter int                    ADDR_SIZE    = 4,
  parameter int                    PAYLOAD_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0]  REG_ADDR     = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]     rec_msg,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]     send_msg,
  output logic [PAYLOAD_SIZE-1:0]             config_out
);

  localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;

  logic [ADDR_SIZE-1:0]    msg_addr;
  logic                    msg_wr;
  logic [PAYLOAD_SIZE-1:0] msg_payload;
  logic                    match;

  logic [PAYLOAD_SIZE-1:0] value_q;
  logic [PAYLOAD_SIZE-1:0] value_d;
  logic [MSG_W-1:0]        send_q;
  logic [MSG_W-1:0]        send_d;

  always_comb begin
    msg_addr    = rec_msg[ADDR_SIZE+PAYLOAD_SIZE:PAYLOAD_SIZE+1];
    msg_wr      = rec_msg[PAYLOAD_SIZE];
    msg_payload = rec_msg[PAYLOAD_SIZE-1:0];
    match       = (msg_addr == REG_ADDR);
  end

  // A read answers with the value held before this edge; writes and foreign traffic pass through.
  always_comb begin
    value_d = value_q;
    send_d  = rec_msg;
    if (match) begin
      if (msg_wr) begin
        value_d = msg_payload;
      end else begin
        send_d = {REG_ADDR, 1'b0, value_q};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      send_q  <= '0;
    end else begin
      value_q <= value_d;
      send_q  <= send_d;
    end
  end

  assign send_msg   = send_q;
  assign config_out = value_q;

endmodule

// File: tb/tb_config_reg.sv
// tb/tb_config_reg.sv - scoreboard testbench for config_reg
// Stimulus pushes model expectations; a monitor pops and compares after each rising edge.
module tb_config_reg;

  localparam int AW = 4;
  localparam int PW = 8;
  localparam int MW = AW + PW + 1;
  localparam logic [AW-1:0] RADDR = 4'd0;

  typedef struct {
    logic [MW-1:0] send;
    logic [PW-1:0] cfg;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [MW-1:0] rec_msg;
  logic [MW-1:0] send_msg;
  logic [PW-1:0] config_out;

  exp_t          exp_q[$];
  logic [PW-1:0] ref_val;
  int            n_tests;
  int            n_fail;

  config_reg #(.ADDR_SIZE(AW), .PAYLOAD_SIZE(PW), .REG_ADDR(RADDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .rec_msg    (rec_msg),
    .send_msg   (send_msg),
    .config_out (config_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mk(input logic [AW-1:0] a, input logic w, input logic [PW-1:0] p);
    return {a, w, p};
  endfunction

  task automatic check_send(input string name, input logic [MW-1:0] got, input logic [MW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: send_msg got %b_%b_%h want %b_%b_%h", name,
               got[MW-1:PW+1], got[PW], got[PW-1:0], want[MW-1:PW+1], want[PW], want[PW-1:0]);
    end
  endtask

  task automatic check_cfg(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: config_out got %h want %h", name, got, want);
    end
  endtask

  // Reference: the node's observable contract, one message per edge.
  task automatic send(input logic [MW-1:0] msg);
    exp_t e;
    logic [AW-1:0] a;
    logic          w;
    logic [PW-1:0] p;
    @(negedge clk);
    reset   = 1'b1;
    rec_msg = msg;
    a = msg[MW-1:PW+1];
    w = msg[PW];
    p = msg[PW-1:0];
    if (a == RADDR && w) begin
      ref_val = p;
      e.send  = msg;
    end else if (a == RADDR) begin
      e.send  = {RADDR, 1'b0, ref_val};
    end else begin
      e.send  = msg;
    end
    e.cfg = ref_val;
    exp_q.push_back(e);
  endtask

  task automatic hold_reset(input logic [MW-1:0] msg);
    exp_t e;
    @(negedge clk);
    reset   = 1'b0;
    rec_msg = msg;
    ref_val = '0;
    e.send  = '0;
    e.cfg   = '0;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_send("mon_send", send_msg, e.send);
        check_cfg("mon_cfg", config_out, e.cfg);
      end
    end
  end

  initial begin : stimulus
    logic [AW-1:0] a;
    n_tests = 0;
    n_fail  = 0;
    ref_val = '0;
    reset   = 1'b0;
    rec_msg = mk(4'b0000, 1'b0, 8'hFF);
    #1;
    check_send("reset_init_send", send_msg, '0);
    check_cfg("reset_init_cfg", config_out, 8'h00);

    repeat (3) hold_reset(mk(4'b0000, 1'b0, 8'hFF));

    send(mk(4'b0000, 1'b1, 8'h55));
    send(mk(4'b0000, 1'b0, 8'h55));
    send(mk(4'b0000, 1'b0, 8'hFF));
    send(mk(4'b0101, 1'b1, 8'h55));
    send(mk(4'b0101, 1'b0, 8'h55));
    send(mk(4'b0000, 1'b1, 8'h11));
    send(mk(4'b0000, 1'b1, 8'h22));
    send(mk(4'b0000, 1'b0, 8'h00));
    send(mk(4'b1111, 1'b1, 8'hEE));
    send(mk(4'b0000, 1'b1, 8'hA3));

    // Asynchronous reset between edges must clear outputs without a clock.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_send("async_reset_send", send_msg, '0);
    check_cfg("async_reset_cfg", config_out, 8'h00);
    ref_val = '0;
    repeat (2) hold_reset(mk(4'b0000, 1'b1, 8'h77));

    send(mk(4'b0000, 1'b1, 8'h3C));
    send(mk(4'b0000, 1'b0, 8'h00));
    send(mk(4'b0011, 1'b0, 8'h99));

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 1) == 0) ? RADDR : AW'($urandom);
      if (i % 97 == 96) begin
        hold_reset(mk(a, 1'($urandom), 8'($urandom)));
      end else begin
        send(mk(a, 1'($urandom), 8'($urandom)));
      end
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/config_reg.md
Name: config_reg

Overview:
- Single addressable configuration register, one node in a daisy-chained configuration bus.
- Each cycle it samples an incoming message of {address, write flag, payload}.
- On an address match it writes or reads its stored value. Every message is forwarded, or answered, downstream one cycle later.
- The stored value drives `config_out` to the block it configures.

Parameters:
- ADDR_SIZE, 4: width of the address field.
- PAYLOAD_SIZE, 8: width of the payload field and of the stored register.
- REG_ADDR, 0: this register's address, ADDR_SIZE bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rec_msg  input  ADDR_SIZE+PAYLOAD_SIZE+1  incoming configuration message.
- send_msg  output  ADDR_SIZE+PAYLOAD_SIZE+1  outgoing message to the next node; registered.
- config_out  output  PAYLOAD_SIZE  current stored configuration value; registered.

Behaviour:
- Message format, MSB to LSB:
  - addr = msg[ADDR_SIZE+PAYLOAD_SIZE : PAYLOAD_SIZE+1]
  - wr = msg[PAYLOAD_SIZE]
  - payload = msg[PAYLOAD_SIZE-1:0]
- Reset: reset low immediately clears the stored value, config_out and send_msg to all zeros, independent of clk. State holds at zero while reset is low. The first rec_msg is processed on the first rising edge after reset goes high.
- Match means addr == REG_ADDR, all ADDR_SIZE bits compared.
- Every rising edge with reset high:
  - Match and wr=1 (write):
    - Stored value <= payload.
    - send_msg <= rec_msg unchanged; the write is echoed downstream.
  - Match and wr=0 (read):
    - Stored value unchanged.
    - send_msg <= {REG_ADDR, 1'b0, stored value before this edge}.
  - No match, either wr value:
    - Stored value unchanged.
    - send_msg <= rec_msg unchanged; pass-through.
- config_out always equals the stored value.
  - After a write edge it shows the new payload in the same cycle that send_msg shows the echo.
- Latency: exactly one clock from rec_msg to send_msg and to config_out. There is no combinational path from input to output.
- No valid/ready handshake; a message is consumed every cycle. An all-zero idle message with wr=0 reads this register when REG_ADDR=0. This is benign: it is a read, not a write.
- Back-to-back writes to the same address: the last one wins; each is echoed.
- A write followed immediately by a read returns the newly written value, since the read samples the stored value after the write edge.
- Reset asserted mid-stream: outputs go to zero asynchronously. A message presented during reset is lost, not forwarded.
- No arithmetic; widths are fixed by the parameters. No truncation or extension occurs.

Test Plan (ADDR_SIZE=4, PAYLOAD_SIZE=8, REG_ADDR=0; msg written addr_wr_payload):
- Reset: reset=0, rec_msg=0000_0_11111111 across edges -> send_msg=0, config_out=0x00.
- Match write: reset=1, rec_msg=0000_1_01010101 -> after one edge config_out=0x55, send_msg=0000_1_01010101.
- Match read: rec_msg=0000_0_01010101 with stored value 0x55 -> send_msg=0000_0_01010101, config_out stays 0x55.
  - Repeat with payload 0xFF -> send_msg payload still 0x55.
- Mismatch write: rec_msg=0101_1_01010101 -> config_out unchanged; send_msg=0101_1_01010101 one cycle later.
- Mismatch read: rec_msg=0101_0_01010101 -> send_msg=0101_0_01010101, config_out unchanged.
- Async reset mid-operation: write 0xA3, then pull reset low between edges -> config_out and send_msg read 0 before the next clk edge.
  - Release reset, then write 0x3C followed by a read -> read returns 0000_0_00111100.
